// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between the I-cache and D-cache
// miss paths; one outstanding transaction, completion routed back to its owner.
module l2_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_we,
    output logic              dc_gnt,
    output logic              dc_done,
    output logic              l2_req,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_we,
    input  logic              l2_ack,
    input  logic              l2_done,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  ic_grants,
    output logic [CNT_W-1:0]  dc_grants
);

    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic                owner_dc_q, owner_dc_d;
    logic                last_dc_q, last_dc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                ic_gnt_q, ic_gnt_d;
    logic                dc_gnt_q, dc_gnt_d;
    logic                ic_done_q, ic_done_d;
    logic                dc_done_q, dc_done_d;
    logic                tmo_q, tmo_d;
    logic [CNT_W-1:0]    ic_cnt_q, ic_cnt_d;
    logic [CNT_W-1:0]    dc_cnt_q, dc_cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                pick_dc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d    = state_q;
        owner_dc_d = owner_dc_q;
        last_dc_d  = last_dc_q;
        addr_d     = addr_q;
        we_d       = we_q;
        ic_gnt_d   = 1'b0;
        dc_gnt_d   = 1'b0;
        ic_done_d  = 1'b0;
        dc_done_d  = 1'b0;
        tmo_d      = 1'b0;
        ic_cnt_d   = ic_cnt_q;
        dc_cnt_d   = dc_cnt_q;
        timer_d    = timer_q;
        pick_dc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    // On a tie the requester that did not own the previous transaction wins
                    pick_dc    = dc_req && (!ic_req || !last_dc_q);
                    owner_dc_d = pick_dc;
                    last_dc_d  = pick_dc;
                    addr_d     = pick_dc ? dc_addr : ic_addr;
                    we_d       = pick_dc && dc_we;
                    if (pick_dc) begin
                        dc_gnt_d = 1'b1;
                        dc_cnt_d = sat_inc(dc_cnt_q);
                    end else begin
                        ic_gnt_d = 1'b1;
                        ic_cnt_d = sat_inc(ic_cnt_q);
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (l2_ack) begin
                    timer_d = '0;
                    if (l2_done) begin
                        ic_done_d = !owner_dc_q;
                        dc_done_d = owner_dc_q;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Completion takes priority over an expiry in the same cycle
                if (l2_done) begin
                    ic_done_d = !owner_dc_q;
                    dc_done_d = owner_dc_q;
                    state_d   = S_IDLE;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_dc_q <= 1'b0;
            last_dc_q  <= 1'b1;
            addr_q     <= '0;
            we_q       <= 1'b0;
            ic_gnt_q   <= 1'b0;
            dc_gnt_q   <= 1'b0;
            ic_done_q  <= 1'b0;
            dc_done_q  <= 1'b0;
            tmo_q      <= 1'b0;
            ic_cnt_q   <= '0;
            dc_cnt_q   <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_dc_q <= owner_dc_d;
            last_dc_q  <= last_dc_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            ic_gnt_q   <= ic_gnt_d;
            dc_gnt_q   <= dc_gnt_d;
            ic_done_q  <= ic_done_d;
            dc_done_q  <= dc_done_d;
            tmo_q      <= tmo_d;
            ic_cnt_q   <= ic_cnt_d;
            dc_cnt_q   <= dc_cnt_d;
            timer_q    <= timer_d;
        end
    end

    assign ic_gnt      = ic_gnt_q;
    assign dc_gnt      = dc_gnt_q;
    assign ic_done     = ic_done_q;
    assign dc_done     = dc_done_q;
    assign timeout_err = tmo_q;
    assign l2_req      = (state_q == S_ISSUE);
    assign l2_addr     = addr_q;
    assign l2_we       = we_q;
    assign busy        = (state_q != S_IDLE);
    assign ic_grants   = ic_cnt_q;
    assign dc_grants   = dc_cnt_q;

endmodule
